// File: rtl/uart_block_bridge_if.sv
// uart_block_bridge_if: byte-stream and 128-bit block signals between uart, bridge and SM4 datapath
`timescale 1ns/1ps
interface uart_block_bridge_if;
    logic         rx_pdvalid;
    logic [7:0]   rx_pdata;
    logic         tx_pdvalid;
    logic [7:0]   tx_pdata;
    logic         tx_done;
    logic         blk_out_valid;
    logic [127:0] blk_out_data;
    logic         blk_in_valid;
    logic [127:0] blk_in_data;
    logic         blk_in_ready;
    logic         frame_drop;
    modport master (
        output rx_pdvalid, rx_pdata, tx_done, blk_in_valid, blk_in_data,
        input  tx_pdvalid, tx_pdata, blk_out_valid, blk_out_data, blk_in_ready, frame_drop
    );
    modport slave (
        input  rx_pdvalid, rx_pdata, tx_done, blk_in_valid, blk_in_data,
        output tx_pdvalid, tx_pdata, blk_out_valid, blk_out_data, blk_in_ready, frame_drop
    );
endinterface

// File: rtl/uart_block_bridge.sv
// uart_block_bridge: packs 16 uart bytes into a 128-bit block and serialises result blocks back to bytes
`timescale 1ns/1ps
module uart_block_bridge #(
    parameter int GAP_CYC = 520_830,
    parameter int CNT_W   = 20
) (
    input logic               clk,
    input logic               rst_n,
    uart_block_bridge_if.slave bus_io
);
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_e;
    logic [3:0]       rx_idx_q, rx_idx_d;
    logic [127:0]     rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [127:0]     blk_out_data_q, blk_out_data_d;
    logic             blk_out_valid_q, frame_drop_q;
    logic             expire, rx_last;
    tx_state_e        state_q;
    logic [127:0]     tx_sh_q;
    logic [3:0]       tx_idx_q;
    logic             tx_pdvalid_q, blk_in_ready_q;
    logic [7:0]       tx_pdata_q;
    // An arriving byte always beats gap expiry, so drop and block pulses never coincide.
    always_comb begin
        expire         = (rx_idx_q != 4'd0) && (gap_q == CNT_W'(GAP_CYC - 1)) && !bus_io.rx_pdvalid;
        rx_last        = bus_io.rx_pdvalid && (rx_idx_q == 4'd15);
        rx_sh_d        = bus_io.rx_pdvalid ? {rx_sh_q[119:0], bus_io.rx_pdata} : rx_sh_q;
        rx_idx_d       = bus_io.rx_pdvalid ? rx_idx_q + 4'd1 : (expire ? 4'd0 : rx_idx_q);
        gap_d          = (bus_io.rx_pdvalid || expire || rx_idx_q == 4'd0) ? '0 : gap_q + 1'b1;
        blk_out_data_d = rx_last ? rx_sh_d : blk_out_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_idx_q        <= '0;
            rx_sh_q         <= '0;
            gap_q           <= '0;
            blk_out_data_q  <= '0;
            blk_out_valid_q <= 1'b0;
            frame_drop_q    <= 1'b0;
        end else begin
            rx_idx_q        <= rx_idx_d;
            rx_sh_q         <= rx_sh_d;
            gap_q           <= gap_d;
            blk_out_data_q  <= blk_out_data_d;
            blk_out_valid_q <= rx_last;
            frame_drop_q    <= expire;
        end
    end
    // tx_pdata/tx_pdvalid are loaded on entry to TX_SEND so they appear in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= TX_IDLE;
            tx_sh_q        <= '0;
            tx_idx_q       <= '0;
            tx_pdvalid_q   <= 1'b0;
            tx_pdata_q     <= '0;
            blk_in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: if (bus_io.blk_in_valid) begin
                    tx_sh_q        <= bus_io.blk_in_data;
                    tx_idx_q       <= '0;
                    tx_pdata_q     <= bus_io.blk_in_data[127:120];
                    tx_pdvalid_q   <= 1'b1;
                    blk_in_ready_q <= 1'b0;
                    state_q        <= TX_SEND;
                end
                TX_SEND: begin
                    tx_pdvalid_q <= 1'b0;
                    state_q      <= TX_WAIT;
                end
                TX_WAIT: if (bus_io.tx_done) begin
                    if (tx_idx_q == 4'd15) begin
                        blk_in_ready_q <= 1'b1;
                        state_q        <= TX_IDLE;
                    end else begin
                        tx_sh_q      <= {tx_sh_q[119:0], 8'h00};
                        tx_idx_q     <= tx_idx_q + 4'd1;
                        tx_pdata_q   <= tx_sh_q[119:112];
                        tx_pdvalid_q <= 1'b1;
                        state_q      <= TX_SEND;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end
    assign bus_io.blk_out_valid = blk_out_valid_q;
    assign bus_io.blk_out_data  = blk_out_data_q;
    assign bus_io.frame_drop    = frame_drop_q;
    assign bus_io.tx_pdvalid    = tx_pdvalid_q;
    assign bus_io.tx_pdata      = tx_pdata_q;
    assign bus_io.blk_in_ready  = blk_in_ready_q;
endmodule

// File: tb/tb_uart_block_bridge.sv
// tb_uart_block_bridge: directed checks of rx packing, tx serialising, gap timeout, duplex and reset
`timescale 1ns/1ps
module tb_uart_block_bridge;
    localparam int GAP = 50;
    localparam logic [127:0] T1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] T2 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] T3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] T4 = 128'hCAFEBABE0BADF00D1337C0DEFEEDFACE;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_block_bridge_if bus_io();
    uart_block_bridge #(.GAP_CYC(GAP), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus_io));
    always #5 clk = ~clk;
    int cyc = 0;
    int passed = 0, total = 0;
    int blk_cnt = 0, drop_cnt = 0, blk_cyc = 0, drop_cyc = 0, viol = 0;
    int first_tx_cyc = 0, done_cyc = 0, ready_cyc = 0, tx_cnt = 0;
    int last_rx_cyc = 0, acc_cyc = 0;
    logic [127:0] last_blk = '0;
    logic [7:0] txq[$];
    initial forever @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    // Observes outputs mid-cycle and models the uart transmitter (tx_done 20 cycles after tx_pdvalid).
    initial begin
        logic prev_pv, prev_rdy;
        prev_pv = 1'b0;
        prev_rdy = 1'b1;
        bus_io.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_cnt = 0;
                bus_io.tx_done = 1'b0;
                prev_pv = 1'b0;
                prev_rdy = 1'b1;
            end else begin
                if (bus_io.blk_out_valid) begin blk_cnt++; blk_cyc = cyc; last_blk = bus_io.blk_out_data; end
                if (bus_io.frame_drop) begin drop_cnt++; drop_cyc = cyc; end
                if (bus_io.blk_out_valid && bus_io.frame_drop) viol++;
                if (bus_io.tx_pdvalid && prev_pv) viol++;
                if (bus_io.blk_in_ready && !prev_rdy) ready_cyc = cyc;
                bus_io.tx_done = 1'b0;
                if (bus_io.tx_pdvalid) begin
                    txq.push_back(bus_io.tx_pdata);
                    if (txq.size() == 1) first_tx_cyc = cyc;
                    tx_cnt = 20;
                end else if (tx_cnt != 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin bus_io.tx_done = 1'b1; done_cyc = cyc; end
                end
                prev_pv = bus_io.tx_pdvalid;
                prev_rdy = bus_io.blk_in_ready;
            end
        end
    end
    function automatic logic [127:0] q2blk(input int off);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], (off + i < txq.size()) ? txq[off + i] : 8'h00};
        return r;
    endfunction
    task automatic send_byte(input logic [7:0] b, input int period);
        bus_io.rx_pdvalid = 1'b1;
        bus_io.rx_pdata = b;
        last_rx_cyc = cyc;
        @(negedge clk);
        bus_io.rx_pdvalid = 1'b0;
        repeat (period - 1) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] base, input int period);
        for (int i = 0; i < 16; i++) send_byte(base + 8'(i), period);
    endtask
    task automatic offer(input logic [127:0] d);
        bus_io.blk_in_valid = 1'b1;
        bus_io.blk_in_data = d;
        acc_cyc = cyc;
        @(negedge clk);
        bus_io.blk_in_valid = 1'b0;
    endtask
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus_io.blk_in_ready && n < 2000) begin @(negedge clk); n++; end
        check(tag, 128'(n < 2000), 128'd1);
    endtask
    initial begin
        int b0, d0;
        bus_io.rx_pdvalid = 1'b0;
        bus_io.rx_pdata = '0;
        bus_io.blk_in_valid = 1'b0;
        bus_io.blk_in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_pdvalid", 128'(bus_io.tx_pdvalid), 128'd0);
        check("rst_tx_pdata", 128'(bus_io.tx_pdata), 128'd0);
        check("rst_blk_out_valid", 128'(bus_io.blk_out_valid), 128'd0);
        check("rst_blk_out_data", bus_io.blk_out_data, 128'd0);
        check("rst_blk_in_ready", 128'(bus_io.blk_in_ready), 128'd1);
        check("rst_frame_drop", 128'(bus_io.frame_drop), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // receive ordering
        b0 = blk_cnt;
        send_frame(8'h00, 40);
        check("rx_count", 128'(blk_cnt - b0), 128'd1);
        check("rx_data", last_blk, 128'h000102030405060708090A0B0C0D0E0F);
        check("rx_latency", 128'(blk_cyc - last_rx_cyc), 128'd1);
        check("rx_hold", bus_io.blk_out_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("rx_nodrop", 128'(drop_cnt), 128'd0);
        // transmit ordering
        txq.delete();
        check("tx_ready_idle", 128'(bus_io.blk_in_ready), 128'd1);
        offer(T1);
        check("tx_ready_busy", 128'(bus_io.blk_in_ready), 128'd0);
        wait_ready("tx_done_bound");
        check("tx_nbytes", 128'(txq.size()), 128'd16);
        check("tx_bytes", q2blk(0), T1);
        check("tx_latency", 128'(first_tx_cyc - acc_cyc), 128'd1);
        check("tx_ready_rise", 128'(ready_cyc - done_cyc), 128'd1);
        // gap timeout discards a 5-byte partial frame
        b0 = blk_cnt;
        d0 = drop_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 10);
        send_byte(8'h54, 60);
        check("to_drop_count", 128'(drop_cnt - d0), 128'd1);
        check("to_drop_latency", 128'(drop_cyc - last_rx_cyc), 128'd51);
        check("to_no_block", 128'(blk_cnt - b0), 128'd0);
        send_frame(8'hA0, 10);
        check("to_block_count", 128'(blk_cnt - b0), 128'd1);
        check("to_block_data", last_blk, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        check("to_single_drop", 128'(drop_cnt - d0), 128'd1);
        // byte 2 lands exactly on the expiry cycle
        b0 = blk_cnt;
        d0 = drop_cnt;
        send_byte(8'hC0, GAP);
        for (int i = 1; i < 16; i++) send_byte(8'hC0 + 8'(i), 10);
        check("col_no_drop", 128'(drop_cnt - d0), 128'd0);
        check("col_block_count", 128'(blk_cnt - b0), 128'd1);
        check("col_block_data", last_blk, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        // full duplex with a second block offered while busy
        txq.delete();
        b0 = blk_cnt;
        offer(T2);
        repeat (30) @(negedge clk);
        check("dup_ready_busy", 128'(bus_io.blk_in_ready), 128'd0);
        fork
            send_frame(8'h30, 10);
            begin
                int n = 0;
                bus_io.blk_in_valid = 1'b1;
                bus_io.blk_in_data = T3;
                while (!bus_io.blk_in_ready && n < 2000) begin @(negedge clk); n++; end
                check("dup_accept_bound", 128'(n < 2000), 128'd1);
                check("dup_first_done", 128'(txq.size()), 128'd16);
                @(negedge clk);
                bus_io.blk_in_valid = 1'b0;
            end
        join
        wait_ready("dup_done_bound");
        check("dup_nbytes", 128'(txq.size()), 128'd32);
        check("dup_block1", q2blk(0), T2);
        check("dup_block2", q2blk(16), T3);
        check("dup_rx_count", 128'(blk_cnt - b0), 128'd1);
        check("dup_rx_data", last_blk, 128'h303132333435363738393A3B3C3D3E3F);
        // reset in the middle of rx byte 7 and tx byte 3
        txq.delete();
        offer(T4);
        for (int i = 0; i < 7; i++) send_byte(8'h60 + 8'(i), 7);
        check("mid_tx_bytes", 128'(txq.size()), 128'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_tx_pdvalid", 128'(bus_io.tx_pdvalid), 128'd0);
        check("mrst_tx_pdata", 128'(bus_io.tx_pdata), 128'd0);
        check("mrst_blk_out_valid", 128'(bus_io.blk_out_valid), 128'd0);
        check("mrst_blk_out_data", bus_io.blk_out_data, 128'd0);
        check("mrst_blk_in_ready", 128'(bus_io.blk_in_ready), 128'd1);
        check("mrst_frame_drop", 128'(bus_io.frame_drop), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b0 = blk_cnt;
        d0 = drop_cnt;
        send_frame(8'h80, 10);
        check("post_block_count", 128'(blk_cnt - b0), 128'd1);
        check("post_block_data", last_blk, 128'h808182838485868788898A8B8C8D8E8F);
        check("post_no_drop", 128'(drop_cnt - d0), 128'd0);
        check("post_tx_quiet", 128'(txq.size()), 128'd3);
        check("post_ready", 128'(bus_io.blk_in_ready), 128'd1);
        check("pulse_rules", 128'(viol), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
